ahb5_slave_mem: RTL and testbench

//  Parametrised AHB5 memory slave; next generation of the plain AHB5 slave signal bundle.

---
 rtl/ahb5_slave_mem_if.sv | 28 ++
 rtl/ahb5_slave_mem.sv | 166 ++++++++++++++++
 tb/tb_ahb5_slave_mem.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb5_slave_mem_if.sv
// AHB5 slave-side signal bundle used by ahb5_slave_mem.
interface ahb5_slave_mem_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  hselx;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic                  hready;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hreadyout;
    logic                  hresp;
    logic [DATA_WIDTH-1:0] hrdata;

    modport master (
        output hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb5_slave_mem.sv
// AHB5 memory slave: word memory, byte-lane writes, configurable wait states, two-cycle ERROR.
// Optional AHB5_SLV_PROT_CHECK_EN makes the top quarter of memory write-protected for user accesses.
module ahb5_slave_mem #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic             clk,
    input logic             rst,
    ahb5_slave_mem_if.slave bus
);
    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned OFF_W     = $clog2(BYTES);
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned MEM_BYTES = MEM_DEPTH * BYTES;
`ifdef AHB5_SLV_PROT_CHECK_EN
    localparam int unsigned PRIV_BASE = MEM_BYTES - MEM_BYTES / 4;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic [IDX_W-1:0]    idx_q;
    logic [OFF_W-1:0]    off_q;
    logic [OFF_W-1:0]    mask_q;
    logic                write_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                accept;
    logic                take;
    logic                bad_req;
    logic                prot_bad;
    logic [OFF_W-1:0]    mask_req;
    logic [IDX_W-1:0]    idx_req;
    logic                mem_we;
    logic                rd_load;
    logic                rd_from_bus;
    logic [IDX_W-1:0]    rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [BYTES-1:0]    be;

    logic unused_bits;
    assign unused_bits = ^{bus.hburst, bus.hprot, bus.htrans[0]};

    // Address-phase decode: size mask covers the offset bits below 2**hsize.
    always_comb begin
        mask_req = '0;
        for (int i = 0; i < int'(OFF_W); i++) begin
            mask_req[i] = 3'(i) < bus.hsize;
        end
        idx_req = bus.haddr[OFF_W +: IDX_W];
        accept  = bus.hselx & bus.hready & bus.htrans[1];
`ifdef AHB5_SLV_PROT_CHECK_EN
        prot_bad = bus.hwrite && (64'(bus.haddr) >= 64'(PRIV_BASE)) && !bus.hprot[1];
`else
        prot_bad = 1'b0;
`endif
        bad_req = (64'(bus.haddr) >= 64'(MEM_BYTES))
               || (bus.hsize > 3'(OFF_W))
               || ((bus.haddr[OFF_W-1:0] & mask_req) != '0)
               || prot_bad;
    end

    // Next-state logic; rd_load marks the edge where read data enters hrdata.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        take        = 1'b0;
        rd_load     = 1'b0;
        rd_from_bus = 1'b0;
        mem_we      = (state == ST_DATA) && write_q;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                take = accept;
                if (!accept) begin
                    state_nxt = ST_IDLE;
                end else if (bad_req) begin
                    state_nxt = ST_ERR1;
                end else if (WAIT_STATES == 0) begin
                    state_nxt   = ST_DATA;
                    rd_load     = !bus.hwrite;
                    rd_from_bus = 1'b1;
                end else begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = 4'(WAIT_STATES);
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = ST_DATA;
                    rd_load   = !write_q;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Lanes sharing the upper offset bits with the aligned address are written.
    always_comb begin
        for (int b = 0; b < int'(BYTES); b++) begin
            be[b] = ((OFF_W'(b) ^ off_q) & ~mask_q) == '0;
        end
    end

    // Forward a write committing on this edge into a pipelined read of the same word.
    always_comb begin
        rd_idx  = rd_from_bus ? idx_req : idx_q;
        rd_word = mem[rd_idx];
        if (mem_we && rd_from_bus && (idx_q == rd_idx)) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (be[b]) begin
                    rd_word[8*b +: 8] = bus.hwdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            idx_q         <= '0;
            off_q         <= '0;
            mask_q        <= '0;
            write_q       <= 1'b0;
            bus.hreadyout <= 1'b1;
            bus.hresp     <= 1'b0;
            bus.hrdata    <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            bus.hreadyout <= !((state_nxt == ST_WAIT) || (state_nxt == ST_ERR1));
            bus.hresp     <= (state_nxt == ST_ERR1) || (state_nxt == ST_ERR2);
            if (take) begin
                idx_q   <= idx_req;
                off_q   <= bus.haddr[OFF_W-1:0];
                mask_q  <= mask_req;
                write_q <= bus.hwrite;
            end
            if (rd_load) begin
                bus.hrdata <= rd_word;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (be[b]) begin
                    mem[idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb5_slave_mem.sv
// Scoreboard bench for ahb5_slave_mem: one zero-wait and one three-wait instance behind a select mux.
module tb_ahb5_slave_mem;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sel;
    logic        hselx;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

    ahb5_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
    ahb5_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if3 ();

    assign if0.hselx  = hselx & ~sel;
    assign if3.hselx  = hselx & sel;
    assign if0.haddr  = haddr;   assign if3.haddr  = haddr;
    assign if0.htrans = htrans;  assign if3.htrans = htrans;
    assign if0.hwrite = hwrite;  assign if3.hwrite = hwrite;
    assign if0.hsize  = hsize;   assign if3.hsize  = hsize;
    assign if0.hburst = hburst;  assign if3.hburst = hburst;
    assign if0.hprot  = hprot;   assign if3.hprot  = hprot;
    assign if0.hwdata = hwdata;  assign if3.hwdata = hwdata;
    assign if0.hready = hready;  assign if3.hready = hready;
    assign hready = sel ? if3.hreadyout : if0.hreadyout;
    assign hresp  = sel ? if3.hresp     : if0.hresp;
    assign hrdata = sel ? if3.hrdata    : if0.hrdata;

    ahb5_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(256), .WAIT_STATES(0))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    ahb5_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(256), .WAIT_STATES(3))
        u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic        resp;
        int          waits;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cur_ws = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts low-ready cycles per data phase and pops on completion.
    bit   dp_active = 1'b0;
    int   low_cnt = 0;
    bit   low_resp_bad = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst) begin
            dp_active = 1'b0;
        end else begin
            if (dp_active) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_phase: data phase with no expectation queued");
                    dp_active = 1'b0;
                end else if (!hready) begin
                    low_cnt++;
                    if (hresp !== exp_q[0].resp) low_resp_bad = 1'b1;
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("resp@%0h", mon_e.addr), 32'(hresp), 32'(mon_e.resp));
                    chk($sformatf("waits@%0h", mon_e.addr), 32'(low_cnt), 32'(mon_e.waits));
                    chk($sformatf("wait_resp@%0h", mon_e.addr), 32'(low_resp_bad), 32'd0);
                    if (mon_e.rd && !mon_e.resp)
                        chk($sformatf("rdata@%0h", mon_e.addr), hrdata, mon_e.data);
                    dp_active = 1'b0;
                end
            end
            if (hselx && htrans[1] && hready) begin
                dp_active    = 1'b1;
                low_cnt      = 0;
                low_resp_bad = 1'b0;
            end
        end
    end

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [3:0] prot, input logic [31:0] wdata,
                         input logic [31:0] edata, input bit eresp, input int ewaits);
        exp_t e;
        int   n;
        e.rd = !wr; e.addr = addr; e.data = edata; e.resp = eresp; e.waits = ewaits;
        exp_q.push_back(e);
        hselx = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size; hprot = prot;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!hready && n < 64);
        if (!hready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout@%0h: hready 0 after %0d cycles, required 1", addr, n);
        end
        @(posedge clk);
        #1;
        if (wr) hwdata = wdata;
    endtask

    task automatic wr_ok(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        issue(1'b1, addr, size, 4'b0011, data, 32'd0, 1'b0, cur_ws);
    endtask

    task automatic rd_ok(input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, addr, 3'd2, 4'b0001, 32'd0, exp, 1'b0, cur_ws);
    endtask

    task automatic xfer_err(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [3:0] prot);
        issue(wr, addr, size, prot, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);
    endtask

    task automatic idle(input int n);
        hselx = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; sel = 1'b0;
        hselx = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd2; hburst = 3'd0; hprot = 4'b0011; hwdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readyout0", 32'(if0.hreadyout), 32'd1);
        chk("rst_resp0", 32'(if0.hresp), 32'd0);
        chk("rst_rdata0", if0.hrdata, 32'd0);
        chk("rst_readyout3", 32'(if3.hreadyout), 32'd1);
        chk("rst_resp3", 32'(if3.hresp), 32'd0);
        chk("rst_rdata3", if3.hrdata, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // zero-wait slave: pipelined write/read with forwarding
        wr_ok(32'h10, 3'd2, 32'hDEAD_BEEF);
        rd_ok(32'h10, 32'hDEAD_BEEF);
        // byte and halfword lanes
        wr_ok(32'h10, 3'd2, 32'h1122_3344);
        wr_ok(32'h13, 3'd0, 32'hABAB_ABAB);
        rd_ok(32'h10, 32'hAB22_3344);
        wr_ok(32'h14, 3'd2, 32'h5566_7788);
        wr_ok(32'h16, 3'd1, 32'h9999_AAAA);
        rd_ok(32'h14, 32'h9999_7788);
        // out of range, then OKAY on idle
        xfer_err(1'b0, 32'h400, 3'd2, 4'b0011);
        idle(2);
        chk("okay_after_err_ready", 32'(hready), 32'd1);
        chk("okay_after_err_resp", 32'(hresp), 32'd0);
        // misaligned and oversize errors leave memory untouched
        wr_ok(32'h00, 3'd2, 32'h0BAD_F00D);
        xfer_err(1'b1, 32'h01, 3'd1, 4'b0011);
        rd_ok(32'h00, 32'h0BAD_F00D);
        wr_ok(32'h20, 3'd2, 32'hCAFE_F00D);
        rd_ok(32'h20, 32'hCAFE_F00D);
        xfer_err(1'b1, 32'h22, 3'd2, 4'b0011);
        wr_ok(32'h18, 3'd2, 32'h0102_0304);
        xfer_err(1'b1, 32'h18, 3'd3, 4'b0011);
        rd_ok(32'h20, 32'hCAFE_F00D);
        rd_ok(32'h18, 32'h0102_0304);
        // last word and protection boundary
        issue(1'b1, 32'h2FC, 3'd2, 4'b0001, 32'h0F0E_0D0C, 32'd0, 1'b0, cur_ws);
        rd_ok(32'h2FC, 32'h0F0E_0D0C);
        wr_ok(32'h3FC, 3'd2, 32'h1234_5678);
`ifdef AHB5_SLV_PROT_CHECK_EN
        xfer_err(1'b1, 32'h3FC, 3'd2, 4'b0001);
        rd_ok(32'h3FC, 32'h1234_5678);
`else
        issue(1'b1, 32'h3FC, 3'd2, 4'b0001, 32'h8765_4321, 32'd0, 1'b0, cur_ws);
        rd_ok(32'h3FC, 32'h8765_4321);
`endif
        idle(3);

        // three-wait slave
        sel = 1'b1;
        cur_ws = 3;
        wr_ok(32'h40, 3'd2, 32'h1111_1111);
        rd_ok(32'h40, 32'h1111_1111);
        xfer_err(1'b0, 32'h400, 3'd2, 4'b0011);
        rd_ok(32'h40, 32'h1111_1111);
        idle(6);

        // reset during WAIT aborts the write
        issue(1'b1, 32'h40, 3'd2, 4'b0011, 32'h2222_2222, 32'd0, 1'b0, 3);
        hselx = 1'b0; htrans = 2'b00;
        chk("wait_ready_low", 32'(hready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(hready), 32'd1);
        chk("rst_mid_resp", 32'(hresp), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        rd_ok(32'h40, 32'h1111_1111);
        idle(6);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
